// File: rtl/psk_pkg.sv
// Shared constants, state encoding and Gray maps for the PSK frame source.
package psk_pkg;

  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;
  localparam logic [3:0] MODE_8PSK = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  function automatic logic mode_valid(input logic [3:0] m);
    return (m == MODE_BPSK) || (m == MODE_QPSK) || (m == MODE_MIX) || (m == MODE_8PSK);
  endfunction

  // MIX sends preamble/header as BPSK like every mode, so its payload is plain QPSK.
  function automatic logic [1:0] mode_bps(input logic [3:0] m);
    case (m)
      MODE_BPSK: return 2'd1;
      MODE_8PSK: return 2'd3;
      default:   return 2'd2;
    endcase
  endfunction

  function automatic logic [2:0] gray_qpsk(input logic [1:0] b);
    case (b)
      2'b00:   return 3'd1;
      2'b01:   return 3'd3;
      2'b11:   return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] gray_8psk(input logic [2:0] b);
    case (b)
      3'b000:  return 3'd0;
      3'b001:  return 3'd1;
      3'b011:  return 3'd2;
      3'b010:  return 3'd3;
      3'b110:  return 3'd4;
      3'b111:  return 3'd5;
      3'b101:  return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/psk_lfsr.sv
// Fibonacci PN generator; o_bit is the MSB of the seeded-or-current register,
// so a seed and the first output bit can happen on the same tick.
module psk_lfsr #(
  parameter int                ORDER = 5,
  parameter logic [ORDER-1:0]  TAPS  = 5'b10100
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_seed,
  input  logic i_shift,
  output logic o_bit
);

  logic [ORDER-1:0] r_lfsr;
  logic [ORDER-1:0] w_base;
  logic [ORDER-1:0] w_next;

  assign w_base = i_seed ? {ORDER{1'b1}} : r_lfsr;
  assign w_next = {w_base[ORDER-2:0], ^(w_base & TAPS)};
  assign o_bit  = w_base[ORDER-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_lfsr <= {ORDER{1'b1}};
    else if (i_shift) r_lfsr <= w_next;
    else if (i_seed)  r_lfsr <= {ORDER{1'b1}};
  end

endmodule

// File: rtl/psk_frame_source.sv
// Frame source: PN preamble, frame-counter header, Gray-mapped payload, idle gap.
// One phase index per sym_stb, registered outputs one cycle after the strobe.
module psk_frame_source
  import psk_pkg::*;
#(
  parameter int               PN_ORDER      = 5,
  parameter logic [PN_ORDER-1:0] PN_TAPS    = 5'b10100,
  parameter int               PAYLOAD_BYTES = 8,
  parameter int               GAP_SYMS      = 16
) (
  input  logic       clk_16M384,
  input  logic       rst_16M384,
  input  logic       sym_stb,
  input  logic [3:0] MODE_CTRL,
  input  logic [7:0] data_tdata,
  input  logic       data_tvalid,
  output logic       data_tready,
  output logic [2:0] sym_idx,
  output logic       sym_vld,
  output logic       sym_first,
  output logic       sym_last,
  output logic       busy,
  output logic       underrun
);

  localparam int          PRE_LEN   = (1 << PN_ORDER) - 1;
  localparam logic [15:0] PRE_LAST  = 16'(PRE_LEN - 1);
  localparam logic [15:0] GAP_LAST  = 16'((GAP_SYMS > 0) ? GAP_SYMS - 1 : 0);
  localparam logic [8:0]  PAY_BYTES = 9'(PAYLOAD_BYTES);

  state_t      r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [7:0]  r_fcnt, w_fcnt_n;
  logic [3:0]  r_mode, w_mode_n;
  logic [9:0]  r_buf, w_buf_n, w_buf;
  logic [3:0]  r_nbits, w_nbits_n, w_n, w_bps;
  logic [8:0]  r_bytes, w_bytes_n, w_bytes_left;
  logic        r_und, w_und_n;
  logic [2:0]  r_sym_idx, w_idx, w_bits, w_mask, w_pay_idx;
  logic        r_vld, r_first, r_last;
  logic        w_emit, w_first, w_last, w_take, w_seed, w_shift, w_pn_bit, w_pay_last;
  logic [7:0]  w_byte;

  psk_lfsr #(.ORDER(PN_ORDER), .TAPS(PN_TAPS)) u_pn (
    .i_clk   (clk_16M384),
    .i_rst   (rst_16M384),
    .i_seed  (w_seed),
    .i_shift (w_shift),
    .o_bit   (w_pn_bit)
  );

  // Payload datapath: bits live right-aligned in r_buf, the oldest at r_nbits-1.
  // A byte is pulled only when the buffer cannot fill the next symbol.
  always_comb begin
    w_bps        = {2'b00, mode_bps(r_mode)};
    w_mask       = 3'((4'd1 << w_bps) - 4'd1);
    w_take       = sym_stb && (r_state == S_PAY) && (r_nbits < w_bps) && (r_bytes != 9'd0);
    w_byte       = data_tvalid ? data_tdata : 8'h00;
    w_buf        = w_take ? {r_buf[1:0], w_byte} : r_buf;
    w_n          = w_take ? 4'(r_nbits + 4'd8) : r_nbits;
    w_bytes_left = w_take ? 9'(r_bytes - 9'd1) : r_bytes;
    if (w_n >= w_bps) w_bits = 3'(w_buf >> (w_n - w_bps)) & w_mask;
    else              w_bits = 3'(w_buf << (w_bps - w_n)) & w_mask;
    case (r_mode)
      MODE_BPSK: w_pay_idx = w_bits[0] ? 3'd4 : 3'd0;
      MODE_8PSK: w_pay_idx = gray_8psk(w_bits);
      default:   w_pay_idx = gray_qpsk(w_bits[1:0]);
    endcase
    w_pay_last = (w_bytes_left == 9'd0) && (w_n <= w_bps);
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_fcnt_n  = r_fcnt;
    w_mode_n  = r_mode;
    w_buf_n   = r_buf;
    w_nbits_n = r_nbits;
    w_bytes_n = r_bytes;
    w_und_n   = r_und;
    w_emit    = 1'b0;
    w_first   = 1'b0;
    w_last    = 1'b0;
    w_idx     = 3'd0;
    w_seed    = 1'b0;
    w_shift   = 1'b0;
    if (sym_stb) begin
      case (r_state)
        S_IDLE: begin
          if (data_tvalid && mode_valid(MODE_CTRL)) begin
            w_mode_n  = MODE_CTRL;
            w_und_n   = 1'b0;
            w_seed    = 1'b1;
            w_shift   = 1'b1;
            w_emit    = 1'b1;
            w_first   = 1'b1;
            w_idx     = w_pn_bit ? 3'd4 : 3'd0;
            w_cnt_n   = 16'd1;
            w_state_n = S_PRE;
          end
        end
        S_PRE: begin
          w_shift = 1'b1;
          w_emit  = 1'b1;
          w_idx   = w_pn_bit ? 3'd4 : 3'd0;
          if (r_cnt == PRE_LAST) begin
            w_cnt_n   = 16'd0;
            w_state_n = S_HDR;
          end else begin
            w_cnt_n = r_cnt + 16'd1;
          end
        end
        S_HDR: begin
          w_emit = 1'b1;
          w_idx  = r_fcnt[~r_cnt[2:0]] ? 3'd4 : 3'd0;
          if (r_cnt == 16'd7) begin
            w_fcnt_n  = r_fcnt + 8'd1;
            w_cnt_n   = 16'd0;
            w_buf_n   = 10'd0;
            w_nbits_n = 4'd0;
            w_bytes_n = PAY_BYTES;
            w_state_n = S_PAY;
          end else begin
            w_cnt_n = r_cnt + 16'd1;
          end
        end
        S_PAY: begin
          w_emit    = 1'b1;
          w_idx     = w_pay_idx;
          w_buf_n   = w_buf;
          w_nbits_n = (w_n >= w_bps) ? 4'(w_n - w_bps) : 4'd0;
          w_bytes_n = w_bytes_left;
          if (w_take && !data_tvalid) w_und_n = 1'b1;
          if (w_pay_last) begin
            w_last    = 1'b1;
            w_cnt_n   = 16'd0;
            w_state_n = (GAP_SYMS == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_n   = 16'd0;
            w_state_n = S_IDLE;
          end else begin
            w_cnt_n = r_cnt + 16'd1;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_fcnt    <= 8'd0;
      r_mode    <= MODE_BPSK;
      r_buf     <= 10'd0;
      r_nbits   <= 4'd0;
      r_bytes   <= 9'd0;
      r_und     <= 1'b0;
      r_sym_idx <= 3'd0;
      r_vld     <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_fcnt  <= w_fcnt_n;
      r_mode  <= w_mode_n;
      r_buf   <= w_buf_n;
      r_nbits <= w_nbits_n;
      r_bytes <= w_bytes_n;
      r_und   <= w_und_n;
      r_vld   <= w_emit;
      r_first <= w_first;
      r_last  <= w_last;
      if (w_emit) r_sym_idx <= w_idx;
    end
  end

  assign data_tready = w_take;
  assign sym_idx     = r_sym_idx;
  assign sym_vld     = r_vld;
  assign sym_first   = r_first;
  assign sym_last    = r_last;
  assign busy        = (r_state != S_IDLE);
  assign underrun    = r_und;

endmodule

// File: tb/tb_psk_frame_source.sv
// Bench for psk_frame_source: directed and random frames against a bit-list reference model.
module tb_psk_frame_source;

  localparam logic [3:0] M_BPSK = 4'b0001, M_QPSK = 4'b0010, M_MIX = 4'b0100, M_8PSK = 4'b1000;
  localparam int PB = 8, GAP = 16;

  logic       clk = 1'b0, rst = 1'b1, stb = 1'b0, tvalid = 1'b0, tready;
  logic [3:0] mode = 4'd0;
  logic [7:0] tdata = 8'd0;
  logic [2:0] idx;
  logic       vld, first, last, busy, und;

  psk_frame_source #(.PN_ORDER(5), .PN_TAPS(5'b10100), .PAYLOAD_BYTES(PB), .GAP_SYMS(GAP)) dut (
    .clk_16M384(clk), .rst_16M384(rst), .sym_stb(stb), .MODE_CTRL(mode),
    .data_tdata(tdata), .data_tvalid(tvalid), .data_tready(tready),
    .sym_idx(idx), .sym_vld(vld), .sym_first(first), .sym_last(last),
    .busy(busy), .underrun(und));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] pb_data [PB];
  logic       pb_val  [PB];
  logic [2:0] obs_q[$], exp_q[$], pre_ref[$];
  logic [7:0] exp_fcnt = 8'd0;
  logic       o_vld, o_first, o_last, o_busy, o_und, tr_now;
  logic [2:0] o_idx;
  int         tr_cnt, pre_ticks, first_cnt, first_pos, last_cnt, last_pos, gap_vld;
  logic       und_start, busy_g15, busy_g16;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One symbol slot: strobe for one clock, outputs sampled on the following negedge.
  task automatic tick();
    @(negedge clk); stb = 1'b1;
    #1 tr_now = tready;
    @(negedge clk); stb = 1'b0;
    o_vld = vld; o_idx = idx; o_first = first; o_last = last; o_busy = busy; o_und = und;
    repeat (14) @(negedge clk);
  endtask

  // Reference: frame as a flat bit list, chunked by bits/symbol and mapped through the Gray tables.
  function automatic void build_exp(input logic [3:0] m, input logic [7:0] fc);
    int s, fb, bps, v;
    int bits[$];
    int qt[4] = '{1, 3, 7, 5};
    int et[8] = '{0, 1, 3, 2, 7, 6, 4, 5};
    exp_q.delete();
    s = 31;
    for (int i = 0; i < 31; i++) begin
      exp_q.push_back(((s >> 4) & 1) != 0 ? 3'd4 : 3'd0);
      fb = ((s >> 4) ^ (s >> 2)) & 1;
      s = ((s << 1) | fb) & 31;
    end
    for (int i = 7; i >= 0; i--) exp_q.push_back(fc[i] ? 3'd4 : 3'd0);
    for (int b = 0; b < PB; b++)
      for (int j = 7; j >= 0; j--) bits.push_back(pb_val[b] ? int'(pb_data[b][j]) : 0);
    bps = (m == M_BPSK) ? 1 : (m == M_8PSK) ? 3 : 2;
    for (int p = 0; p < bits.size(); p += bps) begin
      v = 0;
      for (int j = 0; j < bps; j++) v = v * 2 + ((p + j < bits.size()) ? bits[p + j] : 0);
      if (bps == 1)      exp_q.push_back(v != 0 ? 3'd4 : 3'd0);
      else if (bps == 2) exp_q.push_back(3'(qt[v]));
      else               exp_q.push_back(3'(et[v]));
    end
  endfunction

  task automatic run_frame(input string tag, input logic [3:0] m0, input logic [3:0] m1, input bit chain);
    int  k = 0, t = 0;
    bit  got_last = 0, any_bad;
    obs_q.delete();
    tr_cnt = 0; pre_ticks = 0; first_cnt = 0; first_pos = -1; last_cnt = 0; last_pos = -1;
    und_start = 1'bx;
    mode = m0;
    while (!got_last && t < 300) begin
      tdata  = (k < PB) ? pb_data[k] : 8'h00;
      tvalid = (k < PB) ? pb_val[k] : 1'b1;
      tick();
      if (tr_now) begin k++; tr_cnt++; end
      if (o_first) begin first_cnt++; first_pos = obs_q.size(); end
      if (o_vld) begin
        obs_q.push_back(o_idx);
        if (obs_q.size() == 1) begin und_start = o_und; mode = m1; end
        if (o_last) begin got_last = 1; last_cnt++; last_pos = obs_q.size() - 1; end
      end else if (obs_q.size() == 0) pre_ticks++;
      t++;
    end
    chk({tag, "_done"}, 32'(got_last), 32'd1);
    tvalid = chain;
    gap_vld = 0;
    for (int g = 1; g <= GAP; g++) begin
      tick();
      if (o_vld) gap_vld++;
      if (g == GAP - 1) busy_g15 = o_busy;
      if (g == GAP) busy_g16 = o_busy;
    end
    build_exp(m0, exp_fcnt);
    exp_fcnt = exp_fcnt + 8'd1;
    chk({tag, "_nsym"}, obs_q.size(), exp_q.size());
    any_bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin
        any_bad = 1;
        chk($sformatf("%s_idx%0d", tag, i), obs_q[i], exp_q[i]);
      end
    chk({tag, "_idx_all"}, 32'(any_bad), 32'd0);
    chk({tag, "_first"}, first_cnt * 1000 + first_pos, 1000);
    chk({tag, "_last"}, last_cnt * 1000 + last_pos, 1000 + exp_q.size() - 1);
    chk({tag, "_tready"}, tr_cnt, PB);
    chk({tag, "_und_start"}, 32'(und_start), 32'd0);
    chk({tag, "_und_end"}, 32'(o_und), 32'(!(pb_val[0] && pb_val[1] && pb_val[2] && pb_val[3] &&
                                         pb_val[4] && pb_val[5] && pb_val[6] && pb_val[7])));
    chk({tag, "_gap_silent"}, gap_vld, 0);
    chk({tag, "_busy_gap"}, {busy_g15, busy_g16}, 2'b10);
  endtask

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < PB; i++) begin pb_data[i] = b; pb_val[i] = 1'b1; end
  endtask

  initial begin
    // reset state
    #13;
    chk("rst_outs", {idx, vld, first, last, busy, und, tready}, 9'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    // invalid one-hot modes never start a frame
    tvalid = 1'b1; mode = 4'b0011;
    tick(); chk("bad_mode_vld", {o_vld, o_busy}, 2'b00);
    mode = 4'b0000;
    tick(); chk("zero_mode_vld", {o_vld, o_busy}, 2'b00);
    mode = M_BPSK; tvalid = 1'b0;
    tick(); chk("no_tvalid_vld", {o_vld, o_busy}, 2'b00);

    // 1: BPSK 0xA5
    fill(8'hA5);
    run_frame("t1", M_BPSK, M_BPSK, 0);
    chk("t1_pre5", {obs_q[0], obs_q[1], obs_q[2], obs_q[3], obs_q[4]}, {5{3'd4}});
    chk("t1_hdr0", {obs_q[31], obs_q[34], obs_q[38]}, 9'd0);
    chk("t1_pay0", {obs_q[39], obs_q[40], obs_q[41], obs_q[42]}, {3'd4, 3'd0, 3'd4, 3'd0});
    chk("t1_len", obs_q.size(), 31 + 8 + 64);
    for (int i = 0; i < 31; i++) pre_ref.push_back(obs_q[i]);

    // 2: QPSK 0x1E
    fill(8'h1E);
    run_frame("t2", M_QPSK, M_QPSK, 0);
    chk("t2_len", obs_q.size(), 31 + 8 + 32);
    chk("t2_hdr1", obs_q[38], 3'd4);

    // 3: 8PSK 0xFF, padded final symbol
    fill(8'hFF);
    run_frame("t3", M_8PSK, M_8PSK, 0);
    chk("t3_len", obs_q.size(), 31 + 8 + 22);
    chk("t3_mid", obs_q[39 + 20], 3'd5);
    chk("t3_lastidx", obs_q[obs_q.size() - 1], 3'd7);

    // 4: bytes 3 and 4 missing, then a clean frame clears underrun
    for (int i = 0; i < PB; i++) begin pb_data[i] = 8'($urandom); pb_val[i] = 1'b1; end
    pb_val[3] = 1'b0; pb_val[4] = 1'b0;
    run_frame("t4", M_QPSK, M_QPSK, 0);
    chk("t4_und_held", o_und, 1'b1);
    fill(8'h3C);
    run_frame("t4b", M_MIX, M_MIX, 0);

    // 6: reset in the middle of the payload
    fill(8'hA5); mode = M_BPSK; tvalid = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    chk("t6_in_pay", {o_vld, o_busy}, 2'b11);
    @(negedge clk); stb = 1'b1;
    @(posedge clk); #2 rst = 1'b1;
    #1 chk("t6_rst_outs", {idx, vld, first, last, busy, und, tready}, 9'd0);
    @(negedge clk); stb = 1'b0;
    repeat (2) @(negedge clk); rst = 1'b0;
    exp_fcnt = 8'd0;

    // 5: back-to-back frames; mode change mid-frame only affects frame 2
    fill(8'hA5);
    run_frame("t5a", M_BPSK, M_8PSK, 1);
    chk("t6_hdr0", {obs_q[31], obs_q[38]}, 6'd0);
    for (int i = 0; i < 31; i++) chk($sformatf("t6_pre%0d", i), obs_q[i], pre_ref[i]);
    fill(8'h5A);
    run_frame("t5b", M_8PSK, M_8PSK, 0);
    chk("t5_b2b", pre_ticks, 0);
    chk("t5_hdr01", {obs_q[31], obs_q[37], obs_q[38]}, {3'd0, 3'd0, 3'd4});
    chk("t5_len", obs_q.size(), 31 + 8 + 22);

    // random frames
    for (int f = 0; f < 4; f++) begin
      logic [3:0] rm;
      case ($urandom_range(0, 3))
        0: rm = M_BPSK;
        1: rm = M_QPSK;
        2: rm = M_MIX;
        default: rm = M_8PSK;
      endcase
      for (int i = 0; i < PB; i++) begin
        pb_data[i] = 8'($urandom);
        pb_val[i]  = ($urandom_range(0, 5) != 0);
      end
      pb_val[0] = 1'b1;
      run_frame($sformatf("r%0d", f), rm, 4'($urandom_range(1, 8)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
